// File: rtl/seq_multiplier.sv
// Radix-2 shift-add multiplier: one multiplier bit per clock, start/busy/done handshake.
// Define MULT_SIGNED_EN for two's-complement operands and product (default: unsigned).
module seq_multiplier #(
  parameter int unsigned WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;

  logic [PW-1:0]    a_q;
  logic [PW-1:0]    acc_q;
  logic [WIDTH-1:0] b_q;
  logic [CW-1:0]    cnt_q;

  logic             accept_c;
  logic             last_c;
  logic [PW-1:0]    a_ext_c;
  logic [PW-1:0]    acc_sum_c;
  logic             busy_nxt;
  logic             done_nxt;

  assign accept_c = start && ((state == S_IDLE) || (state == S_DONE));
  assign last_c   = (cnt_q == CW'(WIDTH - 1));

`ifdef MULT_SIGNED_EN
  assign a_ext_c = {{WIDTH{multiplicand[WIDTH-1]}}, multiplicand};

  // The final iteration sees the multiplier sign bit, whose weight is negative.
  always_comb begin
    acc_sum_c = acc_q;
    if (b_q[0]) begin
      if (last_c) acc_sum_c = acc_q - a_q;
      else        acc_sum_c = acc_q + a_q;
    end
  end
`else
  assign a_ext_c = {{WIDTH{1'b0}}, multiplicand};

  always_comb begin
    acc_sum_c = acc_q;
    if (b_q[0]) acc_sum_c = acc_q + a_q;
  end
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept_c) state_nxt = S_RUN;
      S_RUN:   if (last_c)   state_nxt = S_DONE;
      S_DONE:  state_nxt = accept_c ? S_RUN : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output decode from the upcoming state; registered below so outputs are flops.
  always_comb begin
    busy_nxt = 1'b0;
    done_nxt = 1'b0;
    case (state_nxt)
      S_RUN:   busy_nxt = 1'b1;
      S_DONE:  done_nxt = 1'b1;
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      product <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      busy <= busy_nxt;
      done <= done_nxt;
      if (accept_c) begin
        a_q   <= a_ext_c;
        b_q   <= multiplier;
        acc_q <= '0;
        cnt_q <= '0;
      end else if (state == S_RUN) begin
        acc_q <= acc_sum_c;
        a_q   <= {a_q[PW-2:0], 1'b0};
        b_q   <= {1'b0, b_q[WIDTH-1:1]};
        cnt_q <= cnt_q + CW'(1);
        if (last_c) product <= acc_sum_c;
      end
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier: table of operand/product vectors plus
// hand-written sequences for mid-run start, back-to-back start and mid-run reset.
module tb_seq_multiplier;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] multiplicand;
  logic [15:0] multiplier;
  logic        busy;
  logic        done;
  logic [31:0] product;

  int tests;
  int fails;

  seq_multiplier #(.WIDTH(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] exp_u;
    logic [31:0] exp_s;
    string       name;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pick(input logic [31:0] u, input logic [31:0] s);
`ifdef MULT_SIGNED_EN
    return s;
`else
    return u;
`endif
  endfunction

  // Issue one operation and check latency, busy duration and product.
  task automatic do_op(input logic [15:0] a, input logic [15:0] b,
                       input logic [31:0] exp, input string name);
    int cycles;
    int busy_cnt;
    int overlap;
    @(negedge clk);
    multiplicand = a;
    multiplier   = b;
    start        = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    cycles   = 0;
    busy_cnt = 0;
    overlap  = 0;
    while (!done && cycles < 40) begin
      if (busy) busy_cnt++;
      @(posedge clk); #1;
      cycles++;
      if (busy && done) overlap++;
    end
    chk({name, " done_seen"}, 64'(done), 64'd1);
    chk({name, " latency"}, 64'(cycles), 64'd16);
    chk({name, " busy_cycles"}, 64'(busy_cnt), 64'd16);
    chk({name, " busy_done_overlap"}, 64'(overlap), 64'd0);
    chk({name, " product"}, 64'(product), 64'(exp));
    @(posedge clk); #1;
    chk({name, " done_drop"}, 64'(done), 64'd0);
    chk({name, " product_hold"}, 64'(product), 64'(exp));
  endtask

  vec_t vecs[7];

  initial begin
    int done_cnt;
    int done_at[$];
    logic [31:0] p;

    tests = 0;
    fails = 0;
    rst = 1'b1;
    start = 1'b0;
    multiplicand = '0;
    multiplier = '0;

    vecs[0] = '{16'h1234, 16'h00FF, 32'h001221CC, 32'h001221CC, "v_1234x00ff"};
    vecs[1] = '{16'hFFFF, 16'hFFFF, 32'hFFFE0001, 32'h00000001, "v_ffffxffff"};
    vecs[2] = '{16'hFFFF, 16'h0002, 32'h0001FFFE, 32'hFFFFFFFE, "v_ffffx0002"};
    vecs[3] = '{16'h0000, 16'hABCD, 32'h00000000, 32'h00000000, "v_0000xabcd"};
    vecs[4] = '{16'h8000, 16'h8000, 32'h40000000, 32'h40000000, "v_8000x8000"};
    vecs[5] = '{16'h7FFF, 16'h8000, 32'h3FFF8000, 32'hC0008000, "v_7fffx8000"};
    vecs[6] = '{16'h0003, 16'h0005, 32'h0000000F, 32'h0000000F, "v_3x5"};

    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset product", 64'(product), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 7; i++)
      do_op(vecs[i].a, vecs[i].b, pick(vecs[i].exp_u, vecs[i].exp_s), vecs[i].name);

    // start pulsed and operands changed mid-run must not disturb the result
    @(negedge clk);
    multiplicand = 16'h1234;
    multiplier   = 16'h00FF;
    start        = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    done_cnt = 0;
    done_at.delete();
    for (int c = 1; c <= 40; c++) begin
      if (c == 5) begin
        start = 1'b1;
        multiplicand = 16'hFFFF;
        multiplier   = 16'hFFFF;
      end
      if (c == 6) start = 1'b0;
      if (c == 9) begin
        multiplicand = 16'h5555;
        multiplier   = 16'hAAAA;
      end
      @(posedge clk); #1;
      if (done) begin
        done_cnt++;
        done_at.push_back(c);
        p = product;
      end
    end
    chk("midrun_start done_count", 64'(done_cnt), 64'd1);
    if (done_cnt >= 1) begin
      chk("midrun_start latency", 64'(done_at[0]), 64'd16);
      chk("midrun_start product", 64'(p), 64'h001221CC);
    end

    // start held high: a result every 17 cycles
    @(negedge clk);
    multiplicand = 16'd3;
    multiplier   = 16'd5;
    start        = 1'b1;
    @(posedge clk); #1;
    done_at.delete();
    for (int c = 1; c <= 55; c++) begin
      @(posedge clk); #1;
      if (done) begin
        done_at.push_back(c);
        chk("b2b product", 64'(product), 64'h0000000F);
        chk("b2b busy_low_in_done", 64'(busy), 64'd0);
      end
    end
    start = 1'b0;
    chk("b2b done_count", 64'(done_at.size()), 64'd3);
    if (done_at.size() == 3) begin
      chk("b2b done0", 64'(done_at[0]), 64'd16);
      chk("b2b done1", 64'(done_at[1]), 64'd33);
      chk("b2b done2", 64'(done_at[2]), 64'd50);
    end
    repeat (20) @(posedge clk);

    // reset at run cycle 8 clears everything at once and suppresses done
    @(negedge clk);
    multiplicand = 16'h1234;
    multiplier   = 16'h00FF;
    start        = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    chk("midrun_rst busy_before", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    chk("midrun_rst busy", 64'(busy), 64'd0);
    chk("midrun_rst done", 64'(done), 64'd0);
    chk("midrun_rst product", 64'(product), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    done_cnt = 0;
    for (int c = 0; c < 25; c++) begin
      @(posedge clk); #1;
      if (done || busy) done_cnt++;
    end
    chk("midrun_rst no_activity", 64'(done_cnt), 64'd0);
    do_op(16'hFFFF, 16'h0002, pick(32'h0001FFFE, 32'hFFFFFFFE), "post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/seq_multiplier.md
# seq_multiplier

Multi-cycle radix-2 shift-add multiplier producing a full-width `2*WIDTH` product from two `WIDTH`-bit operands, one multiplier bit per clock. It is the inverse arithmetic unit to the CPU's combinational `Divider`: its product feeds the divider's dividend path, and it shares the ALU's operand buses. It uses a start/busy/done handshake so the control unit can stall while it runs.

## Interface
- `WIDTH`, default 16: operand width; product is `2*WIDTH`.
- `clk`  input  1  clock; all state updates on the rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `start`  input  1  request; sampled on the rising edge of `clk`.
- `multiplicand`  input  WIDTH  operand A; captured when `start` is accepted.
- `multiplier`  input  WIDTH  operand B; captured when `start` is accepted.
- `busy`  output  1  high while an operation is in progress (RUN state).
- `done`  output  1  one-cycle pulse; `product` is valid while it is high.
- `product`  output  2*WIDTH  result register, held until the next accepted `start`.

## Operation
- States:
  - IDLE: reset state.
  - RUN.
  - DONE.
- Accepting `start`:
  - `start` is accepted when `start=1` and the state is IDLE or DONE.
  - `start` in RUN is ignored; no queuing.
- Accept edge:
  - Latch A into a `2*WIDTH` shift register (zero-extended, or sign-extended under the macro).
  - Latch B into a `WIDTH` shift register.
  - Clear the accumulator and the bit counter.
  - State goes to RUN.
- RUN, each edge:
  - If the B LSB is 1, accumulator += A register.
  - A shifts left 1; B shifts right 1; counter increments.
  - After the `WIDTH`th iteration: copy the accumulator (including that iteration's add) into `product`, state goes to DONE.
- DONE:
  - Lasts exactly one cycle with `done=1`, then IDLE, unless `start` is accepted on that edge, which goes directly to RUN.
- Arithmetic:
  - The accumulator is `2*WIDTH` bits and all adds are modulo `2^(2*WIDTH)`.
  - Unsigned operation cannot overflow.
- `product` is updated only on the DONE transition. The intermediate accumulator is never visible on `product`.
- Operands may change freely after the accept edge and do not affect the result.
- Reset:
  - `rst=1` at any time, including mid-RUN, immediately forces IDLE and clears all registers.
  - Outputs: `busy=0`, `done=0`, `product=0`.
  - The aborted operation produces no `done`.
- Simultaneous `start` and `rst`: reset wins.

## Timing
- Accept edge = E0. `busy=1` from after E0 through the cycle ending at edge E0+`WIDTH`.
- At edge E0+`WIDTH`: `busy` goes to 0, `done` goes to 1, `product` is valid.
- At E0+`WIDTH`+1: `done` goes to 0. `product` is held.
- Latency is `WIDTH` cycles from accept to `done` (16 for the default).
- Back-to-back: `start` held high during the DONE cycle gives a new E0 at E0+`WIDTH`+1. Throughput is one result per `WIDTH`+1 cycles.
- `busy` and `done` are never high together.
- All outputs are registers, with no combinational path from inputs.

## Configuration
- `MULT_SIGNED_EN`, defined: two's-complement operands and product.
  - A is sign-extended on capture.
  - On the final (MSB) iteration, if the B MSB is 1, the accumulator subtracts the A register instead of adding it.
  - Latency is unchanged.
- `MULT_SIGNED_EN`, undefined: unsigned operands, with zero-extension and add on every set bit.

## Test plan
- Reset then `start` with A=`0x1234`, B=`0x00FF` → `done` 16 cycles after accept, `product=0x001221CC`, `busy` high for exactly 16 cycles.
- A=`0xFFFF`, B=`0xFFFF` → `product=0xFFFE0001` unsigned; `0x00000001` with `MULT_SIGNED_EN`. A=`0xFFFF`, B=`0x0002` → `0x0001FFFE` unsigned, `0xFFFFFFFE` signed.
- A=`0x0000`, B=`0xABCD`, then A=`0x8000`, B=`0x8000` → `0x00000000`, then `0x40000000` (both modes).
- `start` pulsed and operands changed mid-RUN → ignored. Result matches the originally captured operands, and only one `done` pulse occurs.
- `start` held high continuously with A=3, B=5 → `done` every 17 cycles, `product=0x0000000F` each time.
- `rst` asserted at RUN cycle 8 → outputs immediately 0 and no `done`. A fresh `start` afterwards completes normally.
